alu_sched: RTL and testbench
============================

Name: alu_sched

Overview:
- Round-robin scheduler that shares the single 8-bit ALU among NUM_REQ requesters.
- Accepts one operation at a time over a valid/ready handshake.
- Drives the ALU opcode and operand inputs, waits out the ALU's registered output, and returns the result to the granted requester tagged with its index.
- Sits between the ALU and the sequencing/control logic (fetch unit, DMA, debug port) that needs arithmetic.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ID_W, 1, width of requester index; must equal clog2(NUM_REQ), min 1

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester operation request
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- req_inst  in  4*NUM_REQ  opcode, requester i at bits [4i+3:4i]
- req_op1  in  8*NUM_REQ  operand_1, requester i at [8i+7:8i]
- req_op2  in  8*NUM_REQ  operand_2, same packing
- resp_valid  out  NUM_REQ  one-cycle result strobe to the granted requester
- resp_id  out  ID_W  index of responding requester
- resp_data  out  8  result
- resp_err  out  1  illegal-opcode flag, qualified by resp_valid
- alu_inst  out  4  to ALU inst
- alu_operand_1  out  8  to ALU operand_1
- alu_operand_2  out  8  to ALU operand_2
- alu_sol  in  8  from ALU sol (registered in ALU)
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, rr pointer=0, req_ready=0, resp_valid=0, resp_id=0, resp_data=0, resp_err=0, alu_inst=0 (NOP), alu operands=0, busy=0.
- States: IDLE, EXEC, SAMPLE, RESP.
- IDLE:
  - If any req_valid is set, pick the winner g: first valid at or after the pointer, wrapping modulo NUM_REQ.
  - req_ready[g]=1 combinationally in the same cycle; the handshake completes that cycle.
  - On the clock edge, latch opcode, operands and g into the ALU drive registers, then go to EXEC.
  - Pointer becomes (g+1) mod NUM_REQ.
  - With no valid request, stay in IDLE.
- EXEC: ALU inputs are stable; the ALU captures its result at the end of this cycle. Go to SAMPLE.
- SAMPLE: at the end of the cycle, register alu_sol into resp_data and clear resp_err. Go to RESP.
- RESP: resp_valid[g]=1 and resp_id=g for exactly one cycle. No backpressure; the requester must take the result.
  - On the clock edge: alu_inst returns to 0 (NOP), state returns to IDLE.
  - The next grant can happen in the following IDLE cycle.
- Latency: handshake in cycle N, resp_valid in cycle N+3. Throughput is one operation per 4 cycles.
- req_ready is 0 in every state except IDLE.
- Arithmetic: the scheduler never modifies data. Results are 8-bit and wrap as the ALU produces them (e.g. 8'h05-8'h07 = 8'hFE).
- Simultaneous requests: strict round-robin. After reset, requester 0 wins a tie.
- A requester that deasserts req_valid before the handshake loses nothing; no state is kept for it.
- resp_data holds its last value outside RESP.
- Reset mid-operation (any state): the transaction is dropped, no resp_valid is issued, and the pointer returns to 0.

Optional Feature:
- Macro: ALU_OPCHECK_EN.
- Defined: opcodes 0 and 10..15 are accepted normally but never issued to the ALU.
  - alu_inst stays 0.
  - The FSM goes IDLE -> RESP directly, with resp_data=8'h00 and resp_err=1.
  - Latency is 1 cycle.
- Undefined: every opcode follows the full EXEC/SAMPLE path and resp_err is tied 0.
  - Illegal opcodes return whatever the ALU drives, which is undefined (high-Z).

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants ALU_NOP=0, ALU_ADD=1, ALU_SUB=2, ALU_AND=3, ALU_OR=4, ALU_XOR=5, ALU_NOT=6, ALU_SHL=7, ALU_SHR=8, ALU_EQ=9, ALU_OP_MAX=9;
  - the scheduler state encoding;
  - data width 8 and opcode width 4.
- One sub-module, rr_arbiter:
  - inputs: request vector, pointer;
  - outputs: one-hot grant and encoded index;
  - purely combinational.
- The pointer register and FSM live in alu_sched.

Test Plan:
- Single op: req 0 sends ADD 8'h12, 8'h34, handshake at cycle N -> resp_valid[0] at N+3, resp_data=8'h46, resp_id=0, resp_err=0.
- Contention: after reset, req 0 (SUB 8'h05, 8'h07) and req 1 (EQ 8'hAA, 8'hAA) are both held valid -> req 0 is served first with 8'hFE, then req 1 with 8'h01. Next simultaneous request: req 0 is granted again only after req 1, confirming the pointer moves.
- Shift boundary: SHL 8'h01, 8'h09 -> 8'h00; SHR 8'h80, 8'h07 -> 8'h01.
- Illegal opcode 4'hC with ALU_OPCHECK_EN -> resp_valid 1 cycle after the handshake, resp_data=8'h00, resp_err=1, alu_inst stays 0.
- Reset asserted during SAMPLE -> no resp_valid in the following cycles, all outputs at reset values, and the next simultaneous request grants req 0.
- Back-to-back: req 1 holds valid continuously for 3 ops -> req_ready pulses every 4 cycles, with exactly 3 resp_valid[1] pulses carrying the correct results.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU opcodes, widths and scheduler state encoding.
package alu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned INST_W = 4;

  localparam logic [INST_W-1:0] ALU_NOP    = 4'd0;
  localparam logic [INST_W-1:0] ALU_ADD    = 4'd1;
  localparam logic [INST_W-1:0] ALU_SUB    = 4'd2;
  localparam logic [INST_W-1:0] ALU_AND    = 4'd3;
  localparam logic [INST_W-1:0] ALU_OR     = 4'd4;
  localparam logic [INST_W-1:0] ALU_XOR    = 4'd5;
  localparam logic [INST_W-1:0] ALU_NOT    = 4'd6;
  localparam logic [INST_W-1:0] ALU_SHL    = 4'd7;
  localparam logic [INST_W-1:0] ALU_SHR    = 4'd8;
  localparam logic [INST_W-1:0] ALU_EQ     = 4'd9;
  localparam logic [INST_W-1:0] ALU_OP_MAX = 4'd9;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StSample,
    StResp
  } sched_state_e;

  function automatic logic op_illegal(input logic [INST_W-1:0] inst);
    return (inst == ALU_NOP) || (inst > ALU_OP_MAX);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    idx_o
);

  logic [NUM_REQ-1:0] rot;
  logic [ID_W:0]      sum;
  logic               found;
  int                 off;

  always_comb begin
    // Rotate so bit 0 is the pointer position, then take the lowest set bit.
    rot   = NUM_REQ'({req_i, req_i} >> ptr_i);
    found = 1'b0;
    off   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = k;
      end
    end
    sum = {1'b0, ptr_i} + (ID_W + 1)'(off);
    if (sum >= (ID_W + 1)'(NUM_REQ)) begin
      sum = sum - (ID_W + 1)'(NUM_REQ);
    end
    idx_o = sum[ID_W-1:0];
    gnt_o = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      gnt_o[i] = found && (idx_o == ID_W'(i));
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one registered 8-bit ALU among NUM_REQ requesters.
// Define ALU_OPCHECK_EN to answer illegal opcodes with resp_err instead of issuing them.
module alu_sched
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [INST_W*NUM_REQ-1:0] req_inst,
  input  logic [DATA_W*NUM_REQ-1:0] req_op1,
  input  logic [DATA_W*NUM_REQ-1:0] req_op2,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [ID_W-1:0]           resp_id,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      resp_err,
  output logic [INST_W-1:0]         alu_inst,
  output logic [DATA_W-1:0]         alu_operand_1,
  output logic [DATA_W-1:0]         alu_operand_2,
  input  logic [DATA_W-1:0]         alu_sol,
  output logic                      busy
);

  sched_state_e      state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d, id_q, id_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [DATA_W-1:0] op1_q, op1_d, op2_q, op2_d, data_q, data_d;
  logic              err_q, err_d;

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic [INST_W-1:0]  sel_inst;
  logic [DATA_W-1:0]  sel_op1, sel_op2;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_arb (
    .req_i(req_valid),
    .ptr_i(ptr_q),
    .gnt_o(gnt),
    .idx_o(gnt_idx)
  );

  // One-hot payload mux driven by the grant.
  always_comb begin
    sel_inst = '0;
    sel_op1  = '0;
    sel_op2  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_inst = req_inst[i*INST_W +: INST_W];
        sel_op1  = req_op1[i*DATA_W +: DATA_W];
        sel_op2  = req_op2[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    inst_d  = inst_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (|req_valid) begin
          ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          id_d  = gnt_idx;
`ifdef ALU_OPCHECK_EN
          if (op_illegal(sel_inst)) begin
            data_d  = '0;
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            inst_d  = sel_inst;
            op1_d   = sel_op1;
            op2_d   = sel_op2;
            state_d = StExec;
          end
`else
          inst_d  = sel_inst;
          op1_d   = sel_op1;
          op2_d   = sel_op2;
          state_d = StExec;
`endif
        end
      end
      StExec:   state_d = StSample;
      StSample: begin
        data_d  = alu_sol;
        err_d   = 1'b0;
        state_d = StResp;
      end
      StResp: begin
        inst_d  = ALU_NOP;
        state_d = StIdle;
      end
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      id_q    <= '0;
      inst_q  <= ALU_NOP;
      op1_q   <= '0;
      op2_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      inst_q  <= inst_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    resp_id    = '0;
    if (state_q == StIdle) begin
      req_ready = gnt;
    end
    if (state_q == StResp) begin
      resp_id = id_q;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        resp_valid[i] = (id_q == ID_W'(i));
      end
    end
  end

  assign resp_data     = data_q;
  assign resp_err      = err_q;
  assign alu_inst      = inst_q;
  assign alu_operand_1 = op1_q;
  assign alu_operand_2 = op2_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched with a registered behavioural ALU.
module tb_alu_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [7:0]  req_inst = '0;
  logic [15:0] req_op1 = '0;
  logic [15:0] req_op2 = '0;
  logic [1:0]  resp_valid;
  logic [0:0]  resp_id;
  logic [7:0]  resp_data;
  logic        resp_err;
  logic [3:0]  alu_inst;
  logic [7:0]  alu_operand_1;
  logic [7:0]  alu_operand_2;
  logic [7:0]  alu_sol = '0;
  logic        busy;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;
  int unsigned r1_cnt   = 0;

  alu_sched #(
    .NUM_REQ(2),
    .ID_W   (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_inst     (req_inst),
    .req_op1      (req_op1),
    .req_op2      (req_op2),
    .resp_valid   (resp_valid),
    .resp_id      (resp_id),
    .resp_data    (resp_data),
    .resp_err     (resp_err),
    .alu_inst     (alu_inst),
    .alu_operand_1(alu_operand_1),
    .alu_operand_2(alu_operand_2),
    .alu_sol      (alu_sol),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (resp_valid[1]) r1_cnt <= r1_cnt + 1;

  // Stand-in ALU: result registered on the clock edge.
  always @(posedge clk) begin
    case (alu_inst)
      4'd1:    alu_sol <= alu_operand_1 + alu_operand_2;
      4'd2:    alu_sol <= alu_operand_1 - alu_operand_2;
      4'd3:    alu_sol <= alu_operand_1 & alu_operand_2;
      4'd4:    alu_sol <= alu_operand_1 | alu_operand_2;
      4'd5:    alu_sol <= alu_operand_1 ^ alu_operand_2;
      4'd6:    alu_sol <= ~alu_operand_1;
      4'd7:    alu_sol <= alu_operand_1 << alu_operand_2;
      4'd8:    alu_sol <= alu_operand_1 >> alu_operand_2;
      4'd9:    alu_sol <= {7'd0, alu_operand_1 == alu_operand_2};
      default: alu_sol <= 8'h00;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_req(input int id, input logic [3:0] inst, input logic [7:0] a,
                         input logic [7:0] b);
    req_inst[id*4 +: 4] = inst;
    req_op1[id*8 +: 8]  = a;
    req_op2[id*8 +: 8]  = b;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_rvalid"}, resp_valid, 0);
    chk({tag, "_rid"}, resp_id, 0);
    chk({tag, "_rdata"}, resp_data, 0);
    chk({tag, "_rerr"}, resp_err, 0);
    chk({tag, "_inst"}, alu_inst, 0);
    chk({tag, "_op1"}, alu_operand_1, 0);
    chk({tag, "_op2"}, alu_operand_2, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // Called at negedge+1 with requests applied; waits (bounded) for a grant.
  task automatic handshake(input logic [1:0] exp_gnt);
    int n;
    n = 0;
    while (req_ready == '0 && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("grant", req_ready, exp_gnt);
  endtask

  // Called at the negedge of the cycle after the handshake.
  task automatic expect_resp(input logic [1:0] ev, input logic [0:0] eid, input logic [3:0] einst,
                             input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] edata,
                             input logic eerr, input int elat);
    int n;
    n = 1;
    #1;
    chk("exec_inst", alu_inst, einst);
    if (einst != 4'd0) begin
      chk("exec_op1", alu_operand_1, ea);
      chk("exec_op2", alu_operand_2, eb);
    end
    chk("busy", busy, 1);
    chk("ready_low", req_ready, 0);
    while (resp_valid == '0 && n < 8) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("latency", n, elat);
    chk("resp_valid", resp_valid, ev);
    chk("resp_id", resp_id, eid);
    chk("resp_data", resp_data, edata);
    chk("resp_err", resp_err, eerr);
    @(negedge clk);
    #1;
    chk("resp_pulse", resp_valid, 0);
    chk("data_hold", resp_data, edata);
    chk("inst_nop", alu_inst, 0);
    chk("idle", busy, 0);
  endtask

  int unsigned t0, t1, t2, r1_base;

  initial begin
    do_reset();

    // Single ADD from requester 0.
    @(negedge clk);
    set_req(0, 4'd1, 8'h12, 8'h34);
    req_valid = 2'b01;
    #1;
    handshake(2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    expect_resp(2'b01, 1'b0, 4'd1, 8'h12, 8'h34, 8'h46, 1'b0, 3);

    // Contention after reset: 0 first, then 1 while 0 still asks, then 0.
    do_reset();
    set_req(0, 4'd2, 8'h05, 8'h07);
    set_req(1, 4'd9, 8'hAA, 8'hAA);
    req_valid = 2'b11;
    #1;
    handshake(2'b01);
    @(negedge clk);
    expect_resp(2'b01, 1'b0, 4'd2, 8'h05, 8'h07, 8'hFE, 1'b0, 3);
    handshake(2'b10);
    @(negedge clk);
    req_valid = 2'b01;
    expect_resp(2'b10, 1'b1, 4'd9, 8'hAA, 8'hAA, 8'h01, 1'b0, 3);
    handshake(2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    expect_resp(2'b01, 1'b0, 4'd2, 8'h05, 8'h07, 8'hFE, 1'b0, 3);

    // Shift boundaries.
    set_req(1, 4'd7, 8'h01, 8'h09);
    req_valid = 2'b10;
    #1;
    handshake(2'b10);
    @(negedge clk);
    req_valid = 2'b00;
    expect_resp(2'b10, 1'b1, 4'd7, 8'h01, 8'h09, 8'h00, 1'b0, 3);
    set_req(0, 4'd8, 8'h80, 8'h07);
    req_valid = 2'b01;
    #1;
    handshake(2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    expect_resp(2'b01, 1'b0, 4'd8, 8'h80, 8'h07, 8'h01, 1'b0, 3);

    // Illegal opcode.
    set_req(1, 4'hC, 8'h33, 8'h44);
    req_valid = 2'b10;
    #1;
    handshake(2'b10);
    @(negedge clk);
    req_valid = 2'b00;
`ifdef ALU_OPCHECK_EN
    expect_resp(2'b10, 1'b1, 4'h0, 8'h00, 8'h00, 8'h00, 1'b1, 1);
`else
    expect_resp(2'b10, 1'b1, 4'hC, 8'h33, 8'h44, 8'h00, 1'b0, 3);
`endif

    // Reset during SAMPLE drops the op and rewinds the pointer.
    set_req(0, 4'd1, 8'h10, 8'h20);
    req_valid = 2'b01;
    #1;
    handshake(2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("no_resp_after_rst", resp_valid, 0);
    end
    set_req(0, 4'd1, 8'h10, 8'h20);
    set_req(1, 4'd4, 8'h0F, 8'hF0);
    req_valid = 2'b11;
    #1;
    handshake(2'b01);
    @(negedge clk);
    req_valid = 2'b10;
    expect_resp(2'b01, 1'b0, 4'd1, 8'h10, 8'h20, 8'h30, 1'b0, 3);
    handshake(2'b10);
    @(negedge clk);
    req_valid = 2'b00;
    expect_resp(2'b10, 1'b1, 4'd4, 8'h0F, 8'hF0, 8'hFF, 1'b0, 3);

    // Back-to-back from requester 1 holding valid.
    r1_base = r1_cnt;
    set_req(1, 4'd5, 8'h5A, 8'hFF);
    req_valid = 2'b10;
    #1;
    handshake(2'b10);
    t0 = cyc;
    @(negedge clk);
    set_req(1, 4'd6, 8'h0F, 8'h00);
    expect_resp(2'b10, 1'b1, 4'd5, 8'h5A, 8'hFF, 8'hA5, 1'b0, 3);
    handshake(2'b10);
    t1 = cyc;
    chk("b2b_gap1", t1 - t0, 4);
    @(negedge clk);
    set_req(1, 4'd3, 8'hF0, 8'h3C);
    expect_resp(2'b10, 1'b1, 4'd6, 8'h0F, 8'h00, 8'hF0, 1'b0, 3);
    handshake(2'b10);
    t2 = cyc;
    chk("b2b_gap2", t2 - t1, 4);
    @(negedge clk);
    req_valid = 2'b00;
    expect_resp(2'b10, 1'b1, 4'd3, 8'hF0, 8'h3C, 8'h30, 1'b0, 3);
    chk("b2b_pulses", r1_cnt - r1_base, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
